// File: rtl/mem_dma_pkg.sv
// Shared types and constants for the memory word-copy initiator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_dma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } dma_state_t;

    // Bytes per memory word; pointers step by this and are aligned to it.
    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/mem_copy_dma.sv
// Word-copy initiator: copies len words src->dst as a second master on the data memory port.
// Latency: 2*len+1 cycles from the start edge to the done pulse (1 cycle for len=0).
// Backpressure: none; start is only sampled in IDLE and ignored while busy.
//
// Ports:
//   clk, rst (async active-low)     - clock and reset
//   start, src_addr, dst_addr, len  - copy request, sampled in IDLE only
//   busy, done                      - port-grant request and one-cycle completion pulse
//   A, WD, We                       - memory address / write data / write enable
//   RD                              - memory read data, combinational from A
module mem_copy_dma
    import mem_dma_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] A,
    output logic [DATA_W-1:0] WD,
    output logic              We,
    input  logic [DATA_W-1:0] RD
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(WORD_BYTES - 1);
    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(WORD_BYTES);

    dma_state_t        state;
    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] dst_ptr;
    logic [LEN_W-1:0]  remaining;
    logic [DATA_W-1:0] data_buf;

    // Pointer arithmetic wraps modulo 2^ADDR_W by construction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
            data_buf  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        src_ptr   <= src_addr & ALIGN_MASK;
                        dst_ptr   <= dst_addr & ALIGN_MASK;
                        remaining <= len;
                        state     <= (len == '0) ? DONE : READ;
                    end
                end
                READ: begin
                    data_buf <= RD;
                    src_ptr  <= src_ptr + STEP;
                    state    <= WRITE;
                end
                WRITE: begin
                    dst_ptr   <= dst_ptr + STEP;
                    remaining <= remaining - LEN_W'(1);
                    // remaining still holds the count including this word
                    state     <= (remaining == LEN_W'(1)) ? DONE : READ;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory pins depend on registered state only, so an async reset
    // drops We/A immediately and start never reaches the memory.
    always_comb begin
        A    = '0;
        WD   = '0;
        We   = 1'b0;
        busy = 1'b1;
        done = 1'b0;
        case (state)
            IDLE:  busy = 1'b0;
            READ:  A    = src_ptr;
            WRITE: begin
                A  = dst_ptr;
                WD = data_buf;
                We = 1'b1;
            end
            DONE:  done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_mem_copy_dma.sv
// Directed bench for mem_copy_dma with a 64-word memory model.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_copy_dma;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] src_addr = '0;
    logic [31:0] dst_addr = '0;
    logic [7:0]  len = '0;
    logic        busy, done, We;
    logic [31:0] A, WD, RD;

    mem_copy_dma #(.DATA_W(32), .ADDR_W(32), .LEN_W(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .busy(busy), .done(done), .A(A), .WD(WD), .We(We), .RD(RD)
    );

    always #5 clk = ~clk;

    // Memory model: one writer process; bench preloads through ld_* / clr.
    logic [31:0] mem [0:63];
    logic        clr = 1'b0;
    logic        ld_en = 1'b0;
    logic [5:0]  ld_idx = '0;
    logic [31:0] ld_dat = '0;

    assign RD = mem[A[7:2]];

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 64; i++) mem[i] <= '0;
        end else if (ld_en) begin
            mem[ld_idx] <= ld_dat;
        end else if (We) begin
            mem[A[7:2]] <= WD;
        end
    end

    int total = 0;
    int bad   = 0;

    logic [31:0] a_log [0:31];
    logic [31:0] we_mask, done_mask, busy_mask;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic mem_clear();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic mem_load(input int idx, input logic [31:0] dat);
        ld_en  = 1'b1;
        ld_idx = idx[5:0];
        ld_dat = dat;
        tick();
        ld_en  = 1'b0;
    endtask

    // Requests a copy; returns during cycle 1 (just after the start edge).
    task automatic kick(input logic [31:0] s, input logic [31:0] d, input logic [7:0] n);
        src_addr = s;
        dst_addr = d;
        len      = n;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        we_mask   = '0;
        done_mask = '0;
        busy_mask = '0;
    endtask

    // Logs cycles first..last, advancing one edge per cycle; start is dropped after each edge.
    task automatic run(input int first, input int last);
        for (int c = first; c <= last; c++) begin
            a_log[c]     = A;
            we_mask[c]   = We;
            done_mask[c] = done;
            busy_mask[c] = busy;
            tick();
            start = 1'b0;
        end
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_we",   {31'b0, We},   32'd0);
        chk("rst_a",    A,             32'd0);
        chk("rst_wd",   WD,            32'd0);
        tick();
        rst = 1'b1;
        tick();

        // Basic copy of 4 words
        mem_clear();
        mem_load(0, 32'h11); mem_load(1, 32'h22); mem_load(2, 32'h33); mem_load(3, 32'h44);
        kick(32'h00, 32'h40, 8'd4);
        run(1, 10);
        chk("basic_we_cycles",   we_mask,   32'h0000_0154);
        chk("basic_done_cycle",  done_mask, 32'h0000_0200);
        chk("basic_busy_cycles", busy_mask, 32'h0000_03FE);
        chk("basic_a_read2",     a_log[5],  32'h08);
        chk("basic_a_write2",    a_log[6],  32'h48);
        chk("basic_mem16", mem[16], 32'h11);
        chk("basic_mem17", mem[17], 32'h22);
        chk("basic_mem18", mem[18], 32'h33);
        chk("basic_mem19", mem[19], 32'h44);

        // Zero length
        kick(32'h00, 32'h40, 8'd0);
        run(1, 3);
        chk("zero_done_cycle", done_mask, 32'h0000_0002);
        chk("zero_we",         we_mask,   32'h0);
        chk("zero_a", a_log[1] | a_log[2] | a_log[3], 32'h0);
        chk("zero_mem16", mem[16], 32'h11);
        chk("zero_mem0",  mem[0],  32'h11);

        // Unaligned addresses
        mem_load(0, 32'hDEAD_BEEF);
        kick(32'h03, 32'h41, 8'd1);
        chk("unal_busy_read", {31'b0, busy}, 32'd1);
        chk("unal_a_read", A, 32'h00);
        chk("unal_we_read", {31'b0, We}, 32'd0);
        tick();
        chk("unal_a_write", A, 32'h40);
        chk("unal_wd_write", WD, 32'hDEAD_BEEF);
        chk("unal_we_write", {31'b0, We}, 32'd1);
        tick();
        chk("unal_done", {31'b0, done}, 32'd1);
        tick();
        chk("unal_mem16", mem[16], 32'hDEAD_BEEF);

        // Busy start ignored, overlapping copy propagates word 0
        mem_clear();
        mem_load(0, 32'hA); mem_load(1, 32'hB); mem_load(2, 32'hC);
        kick(32'h00, 32'h04, 8'd3);
        run(1, 2);
        dst_addr = 32'h80;
        start    = 1'b1;
        run(3, 9);
        chk("ovl_done_cycle", done_mask, 32'h0000_0080);
        chk("ovl_busy_cycles", busy_mask, 32'h0000_00FE);
        chk("ovl_mem1", mem[1], 32'hA);
        chk("ovl_mem2", mem[2], 32'hA);
        chk("ovl_mem3", mem[3], 32'hA);
        chk("ovl_mem32", mem[32], 32'h0);

        // Asynchronous reset in the middle of a WRITE
        mem_clear();
        mem_load(0, 32'h1); mem_load(1, 32'h2); mem_load(2, 32'h3); mem_load(3, 32'h4);
        kick(32'h00, 32'h40, 8'd4);
        run(1, 3);
        #2;
        chk("rstmid_we_before", {31'b0, We}, 32'd1);
        rst = 1'b0;
        #1;
        chk("rstmid_we",   {31'b0, We},   32'd0);
        chk("rstmid_busy", {31'b0, busy}, 32'd0);
        chk("rstmid_a",    A,             32'd0);
        tick();
        chk("rstmid_mem16", mem[16], 32'h1);
        chk("rstmid_mem17", mem[17], 32'h0);
        rst = 1'b1;
        tick();
        kick(32'h08, 32'h60, 8'd1);
        run(1, 4);
        chk("rstmid_after_done", done_mask, 32'h0000_0008);
        chk("rstmid_after_mem24", mem[24], 32'h3);

        // Source pointer wraps past the top of the address space
        mem_clear();
        mem_load(63, 32'h63); mem_load(0, 32'h500);
        kick(32'hFFFF_FFFC, 32'h80, 8'd2);
        run(1, 6);
        chk("wrap_a_read0", a_log[1], 32'hFFFF_FFFC);
        chk("wrap_a_read1", a_log[3], 32'h0000_0000);
        chk("wrap_done",    done_mask, 32'h0000_0020);
        chk("wrap_mem32",   mem[32], 32'h63);
        chk("wrap_mem33",   mem[33], 32'h500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
